// File: rtl/grant_dispatcher.sv
// Grant side of the priority arbitration path: latches the arbiter winner and holds a
// one-hot grant until done. Optional forced release is enabled by GRANT_DISPATCHER_TIMEOUT_EN.
module grant_dispatcher #(
  parameter int unsigned N         = 8,
  parameter int unsigned PRIO_BITS = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 arb_req_i,
  input  logic [$clog2(N)-1:0] arb_sel_i,
  input  logic [PRIO_BITS-1:0] arb_prio_i,
  input  logic [N-1:0]         done_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_sel_o,
  output logic [PRIO_BITS-1:0] gnt_prio_o,
  output logic                 busy_o,
  output logic [N-1:0]         mask_o,
  output logic                 timeout_o
);

  localparam int unsigned SW     = $clog2(N);
  localparam bit          CFG_OK = (N >= 2) && ((N & (N - 1)) == 0) && (TIMEOUT >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("grant_dispatcher: N must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [PRIO_BITS-1:0] prio_q, prio_d;
  logic [N-1:0]        mask_q, mask_d;
  logic                done_hit;

  assign done_hit = done_i[sel_q];

`ifdef GRANT_DISPATCHER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          expire;

  // Counter holds the number of completed GRANT cycles; the last allowed one forces release.
  assign expire = (cnt_q == CW'(TIMEOUT - 1));
`endif

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    mask_d  = mask_q;
`ifdef GRANT_DISPATCHER_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (arb_req_i) begin
          sel_d   = arb_sel_i;
          prio_d  = arb_prio_i;
          gnt_d   = N'(1) << arb_sel_i;
          state_d = ST_GRANT;
`ifdef GRANT_DISPATCHER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        // Only the granted source's done bit matters; arbiter inputs never preempt.
        if (done_hit) begin
          gnt_d   = '0;
          mask_d  = N'(1) << sel_q;
          state_d = ST_RELEASE;
        end
`ifdef GRANT_DISPATCHER_TIMEOUT_EN
        else if (expire) begin
          gnt_d     = '0;
          mask_d    = N'(1) << sel_q;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      ST_RELEASE: begin
        mask_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        mask_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      prio_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      mask_q  <= mask_d;
    end
  end

`ifdef GRANT_DISPATCHER_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_o      = gnt_q;
  assign gnt_sel_o  = sel_q;
  assign gnt_prio_o = prio_q;
  assign mask_o     = mask_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_grant_dispatcher.sv
// Directed self-checking bench for grant_dispatcher (TIMEOUT=4 when the timeout build is used).
module tb_grant_dispatcher;

  localparam int unsigned N  = 8;
  localparam int unsigned PB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          arb_req;
  logic [2:0]    arb_sel;
  logic [PB-1:0] arb_prio;
  logic [N-1:0]  done;
  logic [N-1:0]  gnt;
  logic [2:0]    gnt_sel;
  logic [PB-1:0] gnt_prio;
  logic          busy;
  logic [N-1:0]  mask;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  grant_dispatcher #(.N(N), .PRIO_BITS(PB), .TIMEOUT(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .arb_req_i  (arb_req),
    .arb_sel_i  (arb_sel),
    .arb_prio_i (arb_prio),
    .done_i     (done),
    .gnt_o      (gnt),
    .gnt_sel_o  (gnt_sel),
    .gnt_prio_o (gnt_prio),
    .busy_o     (busy),
    .mask_o     (mask),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic b,
                         input logic [7:0] m, input logic t);
    chk({tag, ".gnt"},     32'(gnt),     32'(g));
    chk({tag, ".busy"},    32'(busy),    32'(b));
    chk({tag, ".mask"},    32'(mask),    32'(m));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    rst = 1'b1; arb_req = 1'b0; arb_sel = '0; arb_prio = '0; done = '0;
    step();
    step();
    chk_out("reset", 8'h00, 1'b0, 8'h00, 1'b0);
    chk("reset.sel", 32'(gnt_sel), 32'd0);
    chk("reset.prio", 32'(gnt_prio), 32'd0);
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("idle", 8'h00, 1'b0, 8'h00, 1'b0);
    end

    // Basic grant sel=5 prio=2, done after three GRANT cycles
    arb_req = 1'b1; arb_sel = 3'd5; arb_prio = 3'd2;
    step();
    chk_out("basic.t", 8'h20, 1'b1, 8'h00, 1'b0);
    chk("basic.prio", 32'(gnt_prio), 32'd2);
    chk("basic.sel", 32'(gnt_sel), 32'd5);
    arb_req = 1'b0;
    step();
    chk_out("basic.t1", 8'h20, 1'b1, 8'h00, 1'b0);
    step();
    chk_out("basic.t2", 8'h20, 1'b1, 8'h00, 1'b0);
    done = 8'h20;
    step();
    chk_out("basic.rel", 8'h00, 1'b1, 8'h20, 1'b0);
    done = 8'h00;
    step();
    chk_out("basic.idle", 8'h00, 1'b0, 8'h00, 1'b0);
    chk("basic.sel_hold", 32'(gnt_sel), 32'd5);
    chk("basic.prio_hold", 32'(gnt_prio), 32'd2);

    // No preemption by a priority-0 winner
    arb_req = 1'b1; arb_sel = 3'd3; arb_prio = 3'd6;
    step();
    chk_out("nopre.g", 8'h08, 1'b1, 8'h00, 1'b0);
    arb_sel = 3'd0; arb_prio = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("nopre.hold", 32'(gnt), 32'h08);
      chk("nopre.prio", 32'(gnt_prio), 32'd6);
    end
    done = 8'h08;
    step();
    chk_out("nopre.rel", 8'h00, 1'b1, 8'h08, 1'b0);
    done = 8'h00;
    step();
    chk_out("nopre.idle", 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    chk_out("nopre.g0", 8'h01, 1'b1, 8'h00, 1'b0);
    chk("nopre.g0prio", 32'(gnt_prio), 32'd0);
    arb_req = 1'b0; done = 8'h01;
    step();
    chk_out("nopre.rel0", 8'h00, 1'b1, 8'h01, 1'b0);
    done = 8'h00;
    step();

    // Done present at the grant edge is ignored; foreign done bits are ignored
    arb_req = 1'b1; arb_sel = 3'd1; arb_prio = 3'd4; done = 8'h02;
    step();
    chk_out("foreign.g", 8'h02, 1'b1, 8'h00, 1'b0);
    arb_req = 1'b0; done = 8'hFD;
    step();
    chk_out("foreign.h1", 8'h02, 1'b1, 8'h00, 1'b0);
    step();
    chk_out("foreign.h2", 8'h02, 1'b1, 8'h00, 1'b0);
    done = 8'h02;
    step();
    chk_out("foreign.rel", 8'h00, 1'b1, 8'h02, 1'b0);
    done = 8'h00;
    step();
    chk_out("foreign.idle", 8'h00, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset in the middle of GRANT
    arb_req = 1'b1; arb_sel = 3'd4; arb_prio = 3'd1;
    step();
    chk("areset.g", 32'(gnt), 32'h10);
    arb_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_out("areset.now", 8'h00, 1'b0, 8'h00, 1'b0);
    chk("areset.sel", 32'(gnt_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0; arb_req = 1'b1; arb_sel = 3'd7; arb_prio = 3'd3;
    step();
    chk_out("areset.g7", 8'h80, 1'b1, 8'h00, 1'b0);
    arb_req = 1'b0; done = 8'h80;
    step();
    chk_out("areset.rel", 8'h00, 1'b1, 8'h80, 1'b0);
    done = 8'h00;
    step();

`ifdef GRANT_DISPATCHER_TIMEOUT_EN
    // Forced release after four GRANT cycles
    arb_req = 1'b1; arb_sel = 3'd2; arb_prio = 3'd5;
    step();
    chk_out("to.c1", 8'h04, 1'b1, 8'h00, 1'b0);
    arb_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("to.hold", 8'h04, 1'b1, 8'h00, 1'b0);
    end
    step();
    chk_out("to.rel", 8'h00, 1'b1, 8'h04, 1'b1);
    step();
    chk_out("to.idle", 8'h00, 1'b0, 8'h00, 1'b0);

    // Done on the fourth GRANT cycle wins over the timeout
    arb_req = 1'b1;
    step();
    chk_out("tod.c1", 8'h04, 1'b1, 8'h00, 1'b0);
    arb_req = 1'b0;
    step();
    step();
    step();
    chk_out("tod.c4", 8'h04, 1'b1, 8'h00, 1'b0);
    done = 8'h04;
    step();
    chk_out("tod.rel", 8'h00, 1'b1, 8'h04, 1'b0);
    done = 8'h00;
    step();
    chk_out("tod.idle", 8'h00, 1'b0, 8'h00, 1'b0);
`else
    // Without the timeout feature a grant persists until done
    arb_req = 1'b1; arb_sel = 3'd2; arb_prio = 3'd5;
    step();
    arb_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_out("persist", 8'h04, 1'b1, 8'h00, 1'b0);
    end
    done = 8'h04;
    step();
    chk_out("persist.rel", 8'h00, 1'b1, 8'h04, 1'b0);
    done = 8'h00;
    step();
    chk_out("persist.idle", 8'h00, 1'b0, 8'h00, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_dispatcher.md
# grant_dispatcher

Sequential grant side of the priority arbitration path. Samples the winning `req_o/sel_o/prio_o` triple from `priority_arbiter` and returns a registered one-hot grant to the selected source. Holds that grant until the source signals completion. Then runs a one-cycle release with a hold-off mask before accepting the next winner, so a granted source never loses its grant mid-transaction when higher priorities appear.

## Interface
- `N`, 8: number of sources; must be a power of two, ≥2 (matches arbiter)
- `PRIO_BITS`, 3: priority width; 0 is highest
- `TIMEOUT`, 255: maximum GRANT cycles before forced release (used only with `GRANT_DISPATCHER_TIMEOUT_EN`); ≥1

- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `arb_req_i`  in  1  arbiter `req_o`: at least one source requesting
- `arb_sel_i`  in  $clog2(N)  arbiter `sel_o`: winning source index
- `arb_prio_i`  in  PRIO_BITS  arbiter `prio_o`: winning priority
- `done_i`  in  N  per-source completion; bit k meaningful only while source k is granted
- `gnt_o`  out  N  one-hot grant, registered
- `gnt_sel_o`  out  $clog2(N)  index of current or last granted source
- `gnt_prio_o`  out  PRIO_BITS  priority latched at grant
- `busy_o`  out  1  high in GRANT or RELEASE
- `mask_o`  out  N  one-hot hold-off of just-released source; upstream ANDs `req_i` with `~mask_o`
- `timeout_o`  out  1  one-cycle pulse on forced release; constant 0 when feature compiled out

## Operation
- Three states: IDLE, GRANT, RELEASE. Encoding is free.
- IDLE:
  - `arb_req_i`=1 at an edge: latch `arb_sel_i` into `gnt_sel_o` and `arb_prio_i` into `gnt_prio_o`; set `gnt_o` = 1<<`arb_sel_i`; go to GRANT.
  - Otherwise stay in IDLE; `gnt_o`=0.
- GRANT:
  - `done_i[gnt_sel_o]`=1 at an edge: `gnt_o`←0, `mask_o`←1<<`gnt_sel_o`, go to RELEASE.
  - All other `done_i` bits are ignored.
  - `arb_*` inputs are ignored; no preemption, including by priority 0.
- RELEASE: exactly one cycle. `mask_o` is held, then cleared; go to IDLE. `arb_req_i` is not sampled in RELEASE.
- `gnt_sel_o` and `gnt_prio_o` hold their values through RELEASE and IDLE until the next grant.
- `busy_o` = (state != IDLE), decoded from registered state.
- `arb_sel_i` ≥ N cannot occur for power-of-two N. No check is required.

## Timing
- Reset (asynchronous assert) takes effect immediately, regardless of state. Reset values:
  - state=IDLE
  - `gnt_o`=0, `gnt_sel_o`=0, `gnt_prio_o`=0
  - `busy_o`=0, `mask_o`=0, `timeout_o`=0
  - timeout counter=0
- A reset asserted mid-GRANT drops the grant without a RELEASE cycle and without `mask_o`.
- Grant latency: `arb_req_i` sampled at edge t → `gnt_o` valid after edge t.
- Release: `done_i` sampled at edge t → `gnt_o`=0 and `mask_o` set after t; IDLE after t+1. The earliest next grant is after t+2.
- `done_i` asserted in the same cycle as the grant edge (state still IDLE) is ignored. The source must hold or reassert `done_i` while in GRANT.
- Minimum grant width: 1 cycle. Done is accepted on the first GRANT edge.
- Back-to-back same source: the masked source cannot win during the RELEASE cycle. It can win at the IDLE edge only if it is still the arbiter winner.

## Configuration
- `GRANT_DISPATCHER_TIMEOUT_EN` defined:
  - Counter of width $clog2(TIMEOUT+1) clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals TIMEOUT−1 at an edge with no done: forced release. Same transitions as done, plus `timeout_o`=1 for the one RELEASE cycle.
  - The grant therefore lasts at most TIMEOUT cycles.
  - If done and timeout occur at the same edge, done wins: normal release, `timeout_o`=0.
- Not defined: no counter; `timeout_o` tied 0; GRANT persists indefinitely until done.

## Test plan
- Reset then idle: `arb_req_i`=0 for 10 cycles → `gnt_o`=0, `busy_o`=0, `mask_o`=0 throughout.
- Basic grant: `arb_req_i`=1, sel=5, prio=2 at edge t → `gnt_o`=8'h20, `gnt_prio_o`=2 after t. `done_i`=8'h20 at t+3 → `gnt_o`=0, `mask_o`=8'h20 after t+3. IDLE after t+4.
- No preemption: grant sel=3, prio=6; then arbiter switches to sel=0, prio=0 for 5 cycles → `gnt_o` stays 8'h08. After done on bit 3, sel=0 granted two edges later.
- Foreign done: grant sel=1, assert `done_i`=8'hFD → grant held. Then `done_i`=8'h02 → release.
- Async reset mid-GRANT: assert `rst_i` between edges → `gnt_o`=0 immediately, no `mask_o`. After deassert, `arb_req_i`=1 sel=7 → `gnt_o`=8'h80 one edge later.
- Timeout (macro on, TIMEOUT=4): grant sel=2, never assert done → `gnt_o` high exactly 4 cycles, then `timeout_o`=1 and `mask_o`=8'h04 for one cycle. Repeat with done on the 4th GRANT cycle → `timeout_o`=0.
